reversalmb_sb_tx_arbiter: RTL

Shares the single sideband transmit port between the REVERSALMB ModuleInitiator and ModulePartner state machines during MBINIT.REVERSALMB. Each requester holds a message request until this block reports it sent. The block then runs the handshake for the granted requester: wait for sideband idle, drive the message, wait for the busy falling edge, and acknowledge. Grants are round-robin, so initiator requests and partner responses interleave without collision.

---
 rtl/reversalmb_sb_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reversalmb_sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// reversalmb_sb_tx_arbiter
//
// Shares the single sideband transmit port between the REVERSALMB
// ModuleInitiator and ModulePartner state machines. Each requester holds a
// request level until it receives its one-cycle o_sent_* pulse. For the
// granted requester the block waits for sideband idle, drives the message,
// waits for the busy falling edge and then pulses o_sent_*. Ties are broken
// round-robin on the last granted requester (init wins the first tie).
//
// Optional feature macro: REVERSALMB_SB_ARB_TIMEOUT_EN
//   When defined, a grant that does not finish within TIMEOUT_CYCLES sets
//   the sticky o_timeout flag and releases the port without an o_sent pulse.
//
// Ports:
//   CLK, rst_n                 clock, asynchronous active-low reset
//   i_enable                   phase active; low aborts and clears outputs
//   i_Busy_SideBand            sideband TX busy
//   i_req_*/i_msg_*/i_dvalid_*/i_data_*   per-requester request and payload
//   o_TX_SbMessage, o_ValidOutData, o_ValidDataFieldParameters, o_TX_Data
//                              registered message to the sideband
//   o_grant                    one-hot grant, bit0 = init, bit1 = part
//   o_sent_init, o_sent_part   one-cycle "message sent" pulses
//   o_timeout                  sticky timeout flag (macro builds only)
// ---------------------------------------------------------------------------
module reversalmb_sb_tx_arbiter #(
  parameter int MSG_W          = 4,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_Busy_SideBand,
  input  logic              i_req_init,
  input  logic              i_req_part,
  input  logic [MSG_W-1:0]  i_msg_init,
  input  logic [MSG_W-1:0]  i_msg_part,
  input  logic              i_dvalid_init,
  input  logic              i_dvalid_part,
  input  logic [DATA_W-1:0] i_data_init,
  input  logic [DATA_W-1:0] i_data_part,
  output logic [MSG_W-1:0]  o_TX_SbMessage,
  output logic              o_ValidOutData,
  output logic              o_ValidDataFieldParameters,
  output logic [DATA_W-1:0] o_TX_Data,
  output logic [1:0]        o_grant,
  output logic              o_sent_init,
  output logic              o_sent_part
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_FALL = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  // 1'b1 = partner was granted last; reset to partner so init wins the first tie
  logic                last_grant_r;
  logic                last_grant_nxt_s;
  logic                busy_d_r;
  logic                fall_s;

  logic [MSG_W-1:0]    msg_r;
  logic [MSG_W-1:0]    msg_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;
  logic                dfv_r;
  logic                dfv_nxt_s;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   data_nxt_s;
  logic [1:0]          grant_r;
  logic [1:0]          grant_nxt_s;
  logic                sent_init_r;
  logic                sent_init_nxt_s;
  logic                sent_part_r;
  logic                sent_part_nxt_s;

  logic                pick_part_s;
  logic [MSG_W-1:0]    win_msg_s;
  logic                win_dvalid_s;
  logic [DATA_W-1:0]   win_data_s;

`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         cnt_r;
  logic [15:0]         cnt_nxt_s;
  logic                timeout_r;
  logic                timeout_nxt_s;
  logic                to_hit_s;
`endif

  assign fall_s = busy_d_r & ~i_Busy_SideBand;

`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
  assign to_hit_s = (cnt_r == TO_LAST);
`endif

  // Round-robin winner: on a tie the requester that was not granted last wins
  always_comb begin
    if (i_req_init && i_req_part) begin
      pick_part_s = ~last_grant_r;
    end else begin
      pick_part_s = i_req_part;
    end
  end

  // Payload mux for the selected requester; data is zeroed when no data field
  always_comb begin
    if (pick_part_s) begin
      win_msg_s    = i_msg_part;
      win_dvalid_s = i_dvalid_part;
      win_data_s   = i_dvalid_part ? i_data_part : {DATA_W{1'b0}};
    end else begin
      win_msg_s    = i_msg_init;
      win_dvalid_s = i_dvalid_init;
      win_data_s   = i_dvalid_init ? i_data_init : {DATA_W{1'b0}};
    end
  end

  // Next-state and next-output logic for the handshake FSM
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    msg_nxt_s        = msg_r;
    valid_nxt_s      = valid_r;
    dfv_nxt_s        = dfv_r;
    data_nxt_s       = data_r;
    grant_nxt_s      = grant_r;
    sent_init_nxt_s  = 1'b0;
    sent_part_nxt_s  = 1'b0;
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
    cnt_nxt_s        = cnt_r;
    timeout_nxt_s    = timeout_r;
`endif

    if (!i_enable) begin
      // Abort: back to idle with every output cleared, arbitration history kept
      state_nxt_s   = ST_IDLE;
      msg_nxt_s     = {MSG_W{1'b0}};
      valid_nxt_s   = 1'b0;
      dfv_nxt_s     = 1'b0;
      data_nxt_s    = {DATA_W{1'b0}};
      grant_nxt_s   = 2'b00;
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
      cnt_nxt_s     = 16'd0;
      timeout_nxt_s = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((i_req_init || i_req_part) && !i_Busy_SideBand) begin
            state_nxt_s      = ST_SEND;
            last_grant_nxt_s = pick_part_s;
            msg_nxt_s        = win_msg_s;
            valid_nxt_s      = 1'b1;
            dfv_nxt_s        = win_dvalid_s;
            data_nxt_s       = win_data_s;
            grant_nxt_s      = pick_part_s ? 2'b10 : 2'b01;
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
            cnt_nxt_s        = 16'd0;
`endif
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end

        ST_SEND: begin
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
          cnt_nxt_s = cnt_r + 16'd1;
          // Timeout is checked first so a late busy rise cannot skip the limit
          if (to_hit_s) begin
            state_nxt_s   = ST_RELEASE;
            timeout_nxt_s = 1'b1;
            msg_nxt_s     = {MSG_W{1'b0}};
            valid_nxt_s   = 1'b0;
            dfv_nxt_s     = 1'b0;
            data_nxt_s    = {DATA_W{1'b0}};
          end else
`endif
          if (i_Busy_SideBand) begin
            state_nxt_s = ST_WAIT_FALL;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end

        ST_WAIT_FALL: begin
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
          cnt_nxt_s = cnt_r + 16'd1;
`endif
          // A completed transfer on the last allowed cycle still counts as sent
          if (fall_s) begin
            state_nxt_s     = ST_RELEASE;
            msg_nxt_s       = {MSG_W{1'b0}};
            valid_nxt_s     = 1'b0;
            dfv_nxt_s       = 1'b0;
            data_nxt_s      = {DATA_W{1'b0}};
            sent_init_nxt_s = grant_r[0];
            sent_part_nxt_s = grant_r[1];
          end
`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
          else if (to_hit_s) begin
            state_nxt_s   = ST_RELEASE;
            timeout_nxt_s = 1'b1;
            msg_nxt_s     = {MSG_W{1'b0}};
            valid_nxt_s   = 1'b0;
            dfv_nxt_s     = 1'b0;
            data_nxt_s    = {DATA_W{1'b0}};
          end
`endif
          else begin
            state_nxt_s = ST_WAIT_FALL;
          end
        end

        ST_RELEASE: begin
          // Requests are ignored here while the requester updates its level
          state_nxt_s = ST_IDLE;
          grant_nxt_s = 2'b00;
        end

        default: begin
          state_nxt_s = ST_IDLE;
          msg_nxt_s   = {MSG_W{1'b0}};
          valid_nxt_s = 1'b0;
          dfv_nxt_s   = 1'b0;
          data_nxt_s  = {DATA_W{1'b0}};
          grant_nxt_s = 2'b00;
        end
      endcase
    end
  end

  // FSM state and round-robin history registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Delayed busy for falling-edge detection
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      busy_d_r <= 1'b0;
    end else begin
      busy_d_r <= i_Busy_SideBand;
    end
  end

  // Registered sideband outputs, grant and sent pulses
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      msg_r       <= {MSG_W{1'b0}};
      valid_r     <= 1'b0;
      dfv_r       <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      grant_r     <= 2'b00;
      sent_init_r <= 1'b0;
      sent_part_r <= 1'b0;
    end else begin
      msg_r       <= msg_nxt_s;
      valid_r     <= valid_nxt_s;
      dfv_r       <= dfv_nxt_s;
      data_r      <= data_nxt_s;
      grant_r     <= grant_nxt_s;
      sent_init_r <= sent_init_nxt_s;
      sent_part_r <= sent_part_nxt_s;
    end
  end

`ifdef REVERSALMB_SB_ARB_TIMEOUT_EN
  // Grant-to-completion counter and sticky timeout flag
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign o_timeout = timeout_r;
`endif

  assign o_TX_SbMessage             = msg_r;
  assign o_ValidOutData             = valid_r;
  assign o_ValidDataFieldParameters = dfv_r;
  assign o_TX_Data                  = data_r;
  assign o_grant                    = grant_r;
  assign o_sent_init                = sent_init_r;
  assign o_sent_part                = sent_part_r;

endmodule
